clcd_refresh_ctrl: RTL and testbench
====================================

Name: clcd_refresh_ctrl

Overview:
- Sequences the board's HD44780-style 2x16 character LCD (CLCD_RS/RW/E/DQ) on behalf of the host interface.
- Holds a 32-byte character shadow buffer written by the host register decoder.
- Runs the LCD power-up init sequence, then pushes the full buffer to the display whenever the buffer changes.
- All LCD bus timing is generated from the 50 MHz system clock.

Parameters:
- T_PWRUP, 750000, cycles to wait after reset before the first command (15 ms).
- T_SETUP, 3, cycles of RS/DQ setup before E rises, and of hold after E falls.
- T_EPW, 12, cycles CLCD_E is held high (240 ns).
- T_CMD, 2000, post-strobe wait for ordinary commands and data (40 us).
- T_CLEAR, 82000, post-strobe wait after the clear command 0x01 (1.64 ms).

Ports:
- clk, input, 1, system clock, 50 MHz.
- RESET, input, 1, synchronous reset, active-high.
- wr_en, input, 1, one-cycle strobe that writes the buffer.
- wr_addr, input, 5, buffer index: 0-15 are line 1, 16-31 are line 2.
- wr_data, input, 8, character code.
- busy, output, 1, high whenever the FSM is not in IDLE.
- init_done, output, 1, high once the init sequence completes; sticky until RESET.
- CLCD_RS, output, 1, LCD register select: 0 = command, 1 = data.
- CLCD_RW, output, 1, tied 0 (write only).
- CLCD_E, output, 1, LCD enable strobe.
- CLCD_DQ, output, 8, LCD data bus.

Behaviour:
- One clock domain, clk. RESET is synchronous, active-high, and has priority over everything else.
- Reset values:
  - CLCD_E = 0, CLCD_RS = 0, CLCD_RW = 0, CLCD_DQ = 8'h00.
  - busy = 1, init_done = 0, dirty = 1.
  - All buffer bytes = 8'h20 (space).
  - State = PWR_WAIT, all counters = 0.
- Buffer writes:
  - On wr_en, buf[wr_addr] <= wr_data and dirty <= 1.
  - Writes are accepted in every state, including during init and mid-refresh.
- Transaction (TX), one LCD byte, all outputs registered:
  - SETUP: T_SETUP cycles; RS and DQ driven, E = 0.
  - PULSE: T_EPW cycles; E = 1.
  - HOLD: T_SETUP cycles; E = 0.
  - WAIT: T_CMD cycles, or T_CLEAR if the byte is command 0x01.
  - Total TX length = 2*T_SETUP + T_EPW + wait, measured from the first SETUP cycle.
  - RS and DQ stay stable from SETUP until the next TX's SETUP.
  - E never glitches and is high for exactly T_EPW consecutive cycles per TX.
- FSM states and transitions:
  - PWR_WAIT: count T_PWRUP cycles, then go to INIT.
  - INIT: issue command TXs (RS = 0) 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 in order. After the WAIT of 0x06, set init_done = 1 and go to IDLE.
  - IDLE: busy = 0. If dirty = 1, go to REFRESH and clear dirty in that same cycle. A wr_en in that same cycle leaves dirty = 1, so the write wins.
  - REFRESH: 34 TXs in order:
    - command 0x80 (RS = 0);
    - data buf[0..15] (RS = 1);
    - command 0xC0 (RS = 0);
    - data buf[16..31] (RS = 1).
    - Each data byte is sampled from the buffer at the start of its SETUP.
    - After the last TX, return to IDLE.
  - A write landing mid-pass sets dirty, which forces one more full pass after the current one completes. Passes are never aborted.
- init_done is 0 throughout PWR_WAIT and INIT.
- Buffer address width is 5 bits, so there is no out-of-range index. The REFRESH index counter runs 0-31 and does not wrap within a pass.
- Reset mid-operation, including mid-PULSE: the next cycle shows E = 0 and all reset values, and the sequence restarts from PWR_WAIT.
- Latency, IDLE with dirty = 1 to first E rise: 1 cycle of state change, then T_SETUP cycles.

Test Plan:
(bench parameters T_PWRUP=20, T_SETUP=2, T_EPW=3, T_CMD=10, T_CLEAR=30)
- Release RESET, no writes -> E pulses carry DQ = 38,38,38,0C,01,06 with RS = 0. The gap after 01 is 30+2 cycles; the others are 10+2. init_done rises after the 0x06 wait. Then one refresh pass: 80, 32x20 (with C0 after 16 bytes), then busy = 0.
- Every E pulse -> exactly 3 cycles high, with DQ/RS stable 2 cycles before the rise and 2 cycles after the fall. CLCD_RW = 0 throughout.
- In IDLE, wr_en at addr 0 with 0x41 and at addr 31 with 0x5A -> one pass: 80, 41, 15x20, C0, 15x20, 5A. busy = 1 during the pass, then 0.
- wr_en at addr 20 with 0x42 during the 5th data TX of a pass -> the current pass completes, then a second pass shows 0x42 at the 5th line-2 byte. After that, IDLE with no further E pulses.
- wr_en coincident with the IDLE-to-REFRESH cycle -> dirty stays 1 and exactly two passes occur.
- Assert RESET during a PULSE cycle -> next cycle E = 0, DQ = 00, busy = 1, init_done = 0. The buffer returns to all 0x20, and the init sequence restarts after 20 cycles.

Source files
------------

// File: rtl/clcd_refresh_ctrl.sv
// clcd_refresh_ctrl
//   Drives an HD44780-style 2x16 character LCD from a 32-byte shadow buffer.
//   After the power-up delay it runs the fixed init command sequence. From
//   then on, every change to the buffer causes one complete redraw of both
//   lines: cursor home for line 1, 16 data bytes, cursor home for line 2,
//   16 data bytes. All bus timing is counted in clk cycles.
//
// Ports
//   clk        system clock
//   RESET      synchronous reset, active high, overrides everything
//   wr_en      one-cycle write strobe into the shadow buffer
//   wr_addr    buffer index (0-15 line 1, 16-31 line 2)
//   wr_data    character code
//   busy       low only while the controller sits in IDLE
//   init_done  set when the init sequence completes, cleared only by RESET
//   CLCD_RS    register select (0 command, 1 data)
//   CLCD_RW    read/write, always write (0)
//   CLCD_E     enable strobe
//   CLCD_DQ    data bus
module clcd_refresh_ctrl #(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 3,
    parameter int T_EPW   = 12,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       init_done,
    output logic       CLCD_RS,
    output logic       CLCD_RW,
    output logic       CLCD_E,
    output logic [7:0] CLCD_DQ
);

    // One shared cycle counter covers every interval, so size it for the longest.
    localparam int CNT_MAX_A = (T_PWRUP > T_CLEAR) ? T_PWRUP : T_CLEAR;
    localparam int CNT_MAX_B = (T_CMD > T_EPW) ? T_CMD : T_EPW;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EPW_LAST   = CNT_W'(T_EPW - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);

    localparam logic [5:0] INIT_LAST_STEP    = 6'd5;
    localparam logic [5:0] REFRESH_LAST_STEP = 6'd33;

    typedef enum logic [1:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        REFRESH
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD,
        PH_WAIT
    } phase_t;

    state_t           state_reg;
    phase_t           phase_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [5:0]       step_reg;
    logic             dirty_reg;
    logic             busy_reg;
    logic             init_done_reg;
    logic             e_reg;
    logic             rs_reg;
    logic [7:0]       dq_reg;

    logic [7:0]       char_buf_reg [32];

    logic [5:0]       step_next;
    logic [4:0]       ref_addr;
    logic             ref_rs;
    logic [7:0]       ref_dq;
    logic [CNT_W-1:0] wait_last;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0, 3'd1, 3'd2: b = 8'h38;  // function set, repeated for a reliable wake-up
            3'd3:             b = 8'h0C;  // display on, cursor off
            3'd4:             b = 8'h01;  // clear display (long execution time)
            3'd5:             b = 8'h06;  // entry mode: increment, no shift
            default:          b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte for the next refresh step. Steps: 0 = line-1 home, 1..16 = buffer
    // 0..15, 17 = line-2 home, 18..33 = buffer 16..31. The buffer is read here,
    // at the edge that starts the byte's SETUP, so late writes are still shown.
    always_comb begin
        step_next = step_reg + 6'd1;
        ref_addr  = 5'd0;
        ref_rs    = 1'b0;
        ref_dq    = 8'h80;
        if (step_next == 6'd17) begin
            ref_dq = 8'hC0;
        end else if (step_next >= 6'd1 && step_next <= 6'd16) begin
            ref_addr = 5'(step_next - 6'd1);
            ref_rs   = 1'b1;
            ref_dq   = char_buf_reg[ref_addr];
        end else if (step_next >= 6'd18) begin
            ref_addr = 5'(step_next - 6'd2);
            ref_rs   = 1'b1;
            ref_dq   = char_buf_reg[ref_addr];
        end
    end

    // Only the clear-display command needs the long post-strobe wait; a data
    // byte of 0x01 (RS = 1) is an ordinary write.
    always_comb begin
        wait_last = CMD_LAST;
        if (!rs_reg && dq_reg == 8'h01) begin
            wait_last = CLEAR_LAST;
        end
    end

    // Shadow buffer. Needs a reset value (spaces), so it is kept in flops.
    always_ff @(posedge clk) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                char_buf_reg[i] <= 8'h20;
            end
        end else if (wr_en) begin
            char_buf_reg[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg     <= PWR_WAIT;
            phase_reg     <= PH_SETUP;
            cnt_reg       <= '0;
            step_reg      <= 6'd0;
            dirty_reg     <= 1'b1;
            busy_reg      <= 1'b1;
            init_done_reg <= 1'b0;
            e_reg         <= 1'b0;
            rs_reg        <= 1'b0;
            dq_reg        <= 8'h00;
        end else begin
            case (state_reg)
                PWR_WAIT: begin
                    if (cnt_reg == PWRUP_LAST) begin
                        state_reg <= INIT;
                        phase_reg <= PH_SETUP;
                        cnt_reg   <= '0;
                        step_reg  <= 6'd0;
                        rs_reg    <= 1'b0;
                        dq_reg    <= init_byte(3'd0);
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                IDLE: begin
                    if (dirty_reg) begin
                        state_reg <= REFRESH;
                        busy_reg  <= 1'b1;
                        dirty_reg <= 1'b0;
                        phase_reg <= PH_SETUP;
                        cnt_reg   <= '0;
                        step_reg  <= 6'd0;
                        rs_reg    <= 1'b0;
                        dq_reg    <= 8'h80;
                    end
                end

                // INIT and REFRESH share the byte transaction engine.
                default: begin
                    case (phase_reg)
                        PH_SETUP: begin
                            if (cnt_reg == SETUP_LAST) begin
                                phase_reg <= PH_PULSE;
                                cnt_reg   <= '0;
                                e_reg     <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end

                        PH_PULSE: begin
                            if (cnt_reg == EPW_LAST) begin
                                phase_reg <= PH_HOLD;
                                cnt_reg   <= '0;
                                e_reg     <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end

                        PH_HOLD: begin
                            if (cnt_reg == SETUP_LAST) begin
                                phase_reg <= PH_WAIT;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end

                        default: begin  // PH_WAIT
                            if (cnt_reg == wait_last) begin
                                cnt_reg   <= '0;
                                phase_reg <= PH_SETUP;
                                if (state_reg == INIT) begin
                                    if (step_reg == INIT_LAST_STEP) begin
                                        state_reg     <= IDLE;
                                        busy_reg      <= 1'b0;
                                        init_done_reg <= 1'b1;
                                    end else begin
                                        step_reg <= step_next;
                                        rs_reg   <= 1'b0;
                                        dq_reg   <= init_byte(step_next[2:0]);
                                    end
                                end else begin
                                    if (step_reg == REFRESH_LAST_STEP) begin
                                        state_reg <= IDLE;
                                        busy_reg  <= 1'b0;
                                    end else begin
                                        step_reg <= step_next;
                                        rs_reg   <= ref_rs;
                                        dq_reg   <= ref_dq;
                                    end
                                end
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                    endcase
                end
            endcase

            // A write always re-arms the redraw, even on the cycle IDLE clears it.
            if (wr_en) begin
                dirty_reg <= 1'b1;
            end
        end
    end

    assign busy      = busy_reg;
    assign init_done = init_done_reg;
    assign CLCD_RS   = rs_reg;
    assign CLCD_RW   = 1'b0;
    assign CLCD_E    = e_reg;
    assign CLCD_DQ   = dq_reg;

endmodule

// File: tb/tb_clcd_refresh_ctrl.sv
module tb_clcd_refresh_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_SETUP = 2;
    localparam int T_EPW   = 3;
    localparam int T_CMD   = 10;
    localparam int T_CLEAR = 30;
    localparam int TX_CMD  = 2 * T_SETUP + T_EPW + T_CMD;    // 17
    localparam int TX_CLR  = 2 * T_SETUP + T_EPW + T_CLEAR;  // 37

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'h00;
    logic       busy;
    logic       init_done;
    logic       CLCD_RS;
    logic       CLCD_RW;
    logic       CLCD_E;
    logic [7:0] CLCD_DQ;

    always #10 clk = ~clk;

    clcd_refresh_ctrl #(
        .T_PWRUP(T_PWRUP),
        .T_SETUP(T_SETUP),
        .T_EPW  (T_EPW),
        .T_CMD  (T_CMD),
        .T_CLEAR(T_CLEAR)
    ) dut (
        .clk      (clk),
        .RESET    (RESET),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .init_done(init_done),
        .CLCD_RS  (CLCD_RS),
        .CLCD_RW  (CLCD_RW),
        .CLCD_E   (CLCD_E),
        .CLCD_DQ  (CLCD_DQ)
    );

    int checks = 0;
    int failures = 0;
    int viol = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] dq;
        logic       rs;
        logic       idone;
        logic       bsy;
        int         cyc;
    } pulse_t;

    pulse_t     pq[$];
    logic [7:0] model_buf [32];
    logic [7:0] init_seq  [6];

    // ---------------- bus monitor (samples on the falling edge) ----------------
    logic       p1_e = 1'b0, p2_e = 1'b0, p1_rs = 1'b0, p2_rs = 1'b0;
    logic [7:0] p1_dq = 8'h00, p2_dq = 8'h00;
    logic [7:0] cur_dq = 8'h00;
    logic       cur_rs = 1'b0;
    int         hi_len = 0;
    int         hold_left = 0;

    always @(negedge clk) begin
        cyc++;
        if (RESET) begin
            p1_e = 1'b0;
            p2_e = 1'b0;
            hi_len = 0;
            hold_left = 0;
        end else begin
            if (CLCD_RW !== 1'b0) viol++;
            if (CLCD_E === 1'b1 && p1_e !== 1'b1) begin
                if (p2_e !== 1'b0 || p1_dq !== CLCD_DQ || p2_dq !== CLCD_DQ ||
                    p1_rs !== CLCD_RS || p2_rs !== CLCD_RS) viol++;
                pq.push_back('{CLCD_DQ, CLCD_RS, init_done, busy, cyc});
                cur_dq = CLCD_DQ;
                cur_rs = CLCD_RS;
                hi_len = 1;
                hold_left = 0;
            end else if (CLCD_E === 1'b1) begin
                hi_len++;
                if (CLCD_DQ !== cur_dq || CLCD_RS !== cur_rs) viol++;
            end else if (p1_e === 1'b1) begin
                if (hi_len != T_EPW) viol++;
                if (CLCD_DQ !== cur_dq || CLCD_RS !== cur_rs) viol++;
                hold_left = T_SETUP - 1;
            end else if (hold_left > 0) begin
                if (CLCD_DQ !== cur_dq || CLCD_RS !== cur_rs) viol++;
                hold_left--;
            end else if (CLCD_E !== 1'b0) begin
                viol++;
            end
            p2_e  = p1_e;
            p2_dq = p1_dq;
            p2_rs = p1_rs;
            p1_e  = CLCD_E;
            p1_dq = CLCD_DQ;
            p1_rs = CLCD_RS;
        end
    end

    // ---------------- helpers (stimulus / model only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        model_buf[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Wait until busy has stayed low for 3 samples (a single low cycle between
    // back-to-back passes does not count).
    task automatic wait_quiet(input int bound, output bit ok);
        int q;
        q  = 0;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (busy === 1'b0) q++;
            else q = 0;
            if (q >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected {RS, DQ} of refresh step i from the bench's copy of the buffer.
    function automatic logic [8:0] exp_tx(input int i);
        if (i == 0)       return {1'b0, 8'h80};
        else if (i <= 16) return {1'b1, model_buf[i-1]};
        else if (i == 17) return {1'b0, 8'hC0};
        else              return {1'b1, model_buf[i-2]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        checks++; if (CLCD_E !== 1'b0)     begin failures++; $display("FAIL reset_e got=%b exp=0", CLCD_E); end
        checks++; if (CLCD_RS !== 1'b0)    begin failures++; $display("FAIL reset_rs got=%b exp=0", CLCD_RS); end
        checks++; if (CLCD_RW !== 1'b0)    begin failures++; $display("FAIL reset_rw got=%b exp=0", CLCD_RW); end
        checks++; if (CLCD_DQ !== 8'h00)   begin failures++; $display("FAIL reset_dq got=%h exp=00", CLCD_DQ); end
        checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (init_done !== 1'b0)  begin failures++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
        $display("test_reset: outputs e=%b rs=%b dq=%h busy=%b init_done=%b", CLCD_E, CLCD_RS, CLCD_DQ, busy, init_done);
    endtask

    task automatic test_init_and_first_pass();
        int n;
        bit ok;
        pq.delete();
        RESET = 1'b0;
        n = 0;
        while (CLCD_E !== 1'b1 && n < 200) begin tick(); n++; end
        checks++; if (n != T_PWRUP + T_SETUP) begin failures++; $display("FAIL pwrup_latency got=%0d exp=%0d", n, T_PWRUP + T_SETUP); end
        wait_quiet(4000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL init_timeout got=busy exp=idle"); end
        checks++; if (pq.size() != 40) begin failures++; $display("FAIL init_pulse_count got=%0d exp=40", pq.size()); end
        if (pq.size() == 40) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if ({pq[i].rs, pq[i].dq} !== {1'b0, init_seq[i]} || pq[i].idone !== 1'b0) begin
                    failures++;
                    $display("FAIL init_byte[%0d] got=rs%b/%h/done%b exp=rs0/%h/done0", i, pq[i].rs, pq[i].dq, pq[i].idone, init_seq[i]);
                end
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (pq[i+1].cyc - pq[i].cyc != ((i == 4) ? TX_CLR : TX_CMD)) begin
                    failures++;
                    $display("FAIL init_period[%0d] got=%0d exp=%0d", i, pq[i+1].cyc - pq[i].cyc, (i == 4) ? TX_CLR : TX_CMD);
                end
            end
            for (int i = 0; i < 34; i++) begin
                checks++;
                if ({pq[6+i].rs, pq[6+i].dq} !== exp_tx(i) || pq[6+i].idone !== 1'b1 || pq[6+i].bsy !== 1'b1) begin
                    failures++;
                    $display("FAIL first_pass[%0d] got=%h done%b busy%b exp=%h done1 busy1", i, {pq[6+i].rs, pq[6+i].dq}, pq[6+i].idone, pq[6+i].bsy, exp_tx(i));
                end
            end
        end
        checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done_final got=%b exp=1", init_done); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL busy_idle got=%b exp=0", busy); end
        $display("test_init_and_first_pass: %0d pulses, init_done=%b busy=%b", pq.size(), init_done, busy);
    endtask

    // Two writes in consecutive IDLE cycles: the second lands on the
    // IDLE-to-REFRESH cycle, so dirty survives and two passes follow.
    task automatic test_back_to_back();
        int n;
        bit ok;
        pq.delete();
        do_write(5'd0, 8'h41);
        do_write(5'd31, 8'h5A);
        n = 0;
        while (CLCD_E !== 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (n != T_SETUP) begin failures++; $display("FAIL idle_latency got=%0d exp=%0d", n, T_SETUP); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_in_pass got=%b exp=1", busy); end
        wait_quiet(4000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=busy exp=idle"); end
        checks++; if (pq.size() != 68) begin failures++; $display("FAIL b2b_pulse_count got=%0d exp=68", pq.size()); end
        if (pq.size() == 68) begin
            for (int i = 0; i < 68; i++) begin
                checks++;
                if ({pq[i].rs, pq[i].dq} !== exp_tx(i % 34)) begin
                    failures++;
                    $display("FAIL b2b_byte[%0d] got=%h exp=%h", i, {pq[i].rs, pq[i].dq}, exp_tx(i % 34));
                end
            end
        end
        $display("test_back_to_back: %0d pulses, busy=%b", pq.size(), busy);
    endtask

    task automatic test_mid_pass_write();
        int n;
        int sz;
        bit ok;
        pq.delete();
        do_write(5'd1, 8'h61);
        n = 0;
        while (pq.size() < 6 && n < 500) begin tick(); n++; end
        checks++; if (pq.size() < 6) begin failures++; $display("FAIL mid_wait_timeout got=%0d exp=6", pq.size()); end
        do_write(5'd20, 8'h42);
        wait_quiet(4000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=busy exp=idle"); end
        checks++; if (pq.size() != 68) begin failures++; $display("FAIL mid_pulse_count got=%0d exp=68", pq.size()); end
        if (pq.size() == 68) begin
            for (int i = 0; i < 68; i++) begin
                checks++;
                if ({pq[i].rs, pq[i].dq} !== exp_tx(i % 34)) begin
                    failures++;
                    $display("FAIL mid_byte[%0d] got=%h exp=%h", i, {pq[i].rs, pq[i].dq}, exp_tx(i % 34));
                end
            end
        end
        sz = pq.size();
        repeat (100) tick();
        checks++; if (pq.size() != sz) begin failures++; $display("FAIL idle_quiet got=%0d exp=%0d", pq.size(), sz); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
        $display("test_mid_pass_write: %0d pulses, line2[4]=%h", sz, model_buf[20]);
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        bit ok;
        do_write(5'd2, 8'h77);
        n = 0;
        while (CLCD_E !== 1'b1 && n < 200) begin tick(); n++; end
        checks++; if (CLCD_E !== 1'b1) begin failures++; $display("FAIL rst_pulse_timeout got=%b exp=1", CLCD_E); end
        RESET = 1'b1;
        tick();
        checks++; if (CLCD_E !== 1'b0)    begin failures++; $display("FAIL rst_mid_e got=%b exp=0", CLCD_E); end
        checks++; if (CLCD_DQ !== 8'h00)  begin failures++; $display("FAIL rst_mid_dq got=%h exp=00", CLCD_DQ); end
        checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", busy); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_mid_init_done got=%b exp=0", init_done); end
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        RESET = 1'b0;
        pq.delete();
        n = 0;
        while (CLCD_E !== 1'b1 && n < 200) begin tick(); n++; end
        checks++; if (n != T_PWRUP + T_SETUP) begin failures++; $display("FAIL rst_restart_latency got=%0d exp=%0d", n, T_PWRUP + T_SETUP); end
        wait_quiet(4000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rst_timeout got=busy exp=idle"); end
        checks++; if (pq.size() != 40) begin failures++; $display("FAIL rst_pulse_count got=%0d exp=40", pq.size()); end
        if (pq.size() == 40) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if ({pq[i].rs, pq[i].dq} !== {1'b0, init_seq[i]}) begin
                    failures++;
                    $display("FAIL rst_init_byte[%0d] got=%h exp=%h", i, {pq[i].rs, pq[i].dq}, {1'b0, init_seq[i]});
                end
            end
            for (int i = 0; i < 34; i++) begin
                checks++;
                if ({pq[6+i].rs, pq[6+i].dq} !== exp_tx(i)) begin
                    failures++;
                    $display("FAIL rst_pass[%0d] got=%h exp=%h", i, {pq[6+i].rs, pq[6+i].dq}, exp_tx(i));
                end
            end
        end
        $display("test_reset_mid_pulse: %0d pulses after restart, init_done=%b", pq.size(), init_done);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
        init_seq[0] = 8'h38;
        init_seq[1] = 8'h38;
        init_seq[2] = 8'h38;
        init_seq[3] = 8'h0C;
        init_seq[4] = 8'h01;
        init_seq[5] = 8'h06;

        test_reset();
        test_init_and_first_pass();
        test_back_to_back();
        test_mid_pass_write();
        test_reset_mid_pulse();

        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL bus_timing got=%0d violations exp=0", viol);
        end
        $display("bus_timing: %0d violations", viol);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
